// File: rtl/sdim_stream_packer.sv
// sdim_stream_packer: packs a one-element-per-beat stream into SDIM-element beats, tlast at each BDIM block end
module sdim_stream_packer #(
  parameter int ELEM_WIDTH = 8,
  parameter int SDIM = 4,
  parameter int BDIM = 16
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [ELEM_WIDTH-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [SDIM*ELEM_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [31:0]                blocks_done
);
  localparam int LW = SDIM > 1 ? $clog2(SDIM) : 1;
  localparam int EW = BDIM > 1 ? $clog2(BDIM) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(SDIM - 1);
  localparam logic [EW-1:0] LAST_ELEM = EW'(BDIM - 1);
  logic [LW-1:0] lane;
  logic [EW-1:0] elem;
  logic [SDIM*ELEM_WIDTH-1:0] pack, beat;
  logic accept, block_end, done;
  assign s_axis_tready = !m_axis_tvalid | m_axis_tready;
  assign accept = s_axis_tvalid & s_axis_tready;
  assign block_end = elem == LAST_ELEM;
  assign done = accept & (lane == LAST_LANE | block_end);
  // lanes above the current one are zero, which pads a short block-end beat
  always_comb begin
    beat = '0;
    for (int i = 0; i < SDIM; i++)
      beat[i*ELEM_WIDTH +: ELEM_WIDTH] = LW'(i) == lane ? s_axis_tdata :
                                         LW'(i) < lane ? pack[i*ELEM_WIDTH +: ELEM_WIDTH] : '0;
  end
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) begin
      lane          <= '0;
      elem          <= '0;
      pack          <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      blocks_done   <= '0;
    end else begin
      if (accept) begin
        lane <= done ? '0 : lane + 1'b1;
        elem <= block_end ? '0 : elem + 1'b1;
        pack <= done ? '0 : beat;
      end
      if (done) begin
        m_axis_tdata <= beat;
        m_axis_tlast <= block_end;
      end
      m_axis_tvalid <= done | (m_axis_tvalid & !m_axis_tready);
      if (m_axis_tvalid & m_axis_tready & m_axis_tlast) blocks_done <= blocks_done + 32'd1;
    end
endmodule

// File: tb/tb_sdim_stream_packer.sv
// tb_sdim_stream_packer: four packer configurations checked against a queue of expected beats
module tb_sdim_stream_packer;
  typedef struct { int d; logic [31:0] data; logic last; } exp_t;
  typedef struct { int d; logic [7:0] first; int n; logic [31:0] data; logic last; } vec_t;
  logic clk = 0, rst = 1;
  logic [7:0] s_data [4];
  logic s_valid [4], sr [4], mv [4], ml [4], mr [4];
  logic [31:0] md [4], bd [4];
  logic [7:0] md_c;
  logic [23:0] md_d;
  int checks = 0, errors = 0;
  exp_t q[$];
  exp_t mon_e;
  vec_t vecs [20];
  logic stalled [4];
  logic [32:0] hold [4];
  logic rand_on = 0;
  always #5 clk = ~clk;
  assign md[2] = {24'd0, md_c};
  assign md[3] = {8'd0, md_d};
  sdim_stream_packer #(.ELEM_WIDTH(8), .SDIM(4), .BDIM(16)) u_a (
    .ap_clk(clk), .ap_rst(rst), .s_axis_tdata(s_data[0]), .s_axis_tvalid(s_valid[0]),
    .s_axis_tready(sr[0]), .m_axis_tdata(md[0]), .m_axis_tvalid(mv[0]),
    .m_axis_tready(mr[0]), .m_axis_tlast(ml[0]), .blocks_done(bd[0]));
  sdim_stream_packer #(.ELEM_WIDTH(8), .SDIM(4), .BDIM(10)) u_b (
    .ap_clk(clk), .ap_rst(rst), .s_axis_tdata(s_data[1]), .s_axis_tvalid(s_valid[1]),
    .s_axis_tready(sr[1]), .m_axis_tdata(md[1]), .m_axis_tvalid(mv[1]),
    .m_axis_tready(mr[1]), .m_axis_tlast(ml[1]), .blocks_done(bd[1]));
  sdim_stream_packer #(.ELEM_WIDTH(8), .SDIM(1), .BDIM(3)) u_c (
    .ap_clk(clk), .ap_rst(rst), .s_axis_tdata(s_data[2]), .s_axis_tvalid(s_valid[2]),
    .s_axis_tready(sr[2]), .m_axis_tdata(md_c), .m_axis_tvalid(mv[2]),
    .m_axis_tready(mr[2]), .m_axis_tlast(ml[2]), .blocks_done(bd[2]));
  sdim_stream_packer #(.ELEM_WIDTH(8), .SDIM(3), .BDIM(7)) u_d (
    .ap_clk(clk), .ap_rst(rst), .s_axis_tdata(s_data[3]), .s_axis_tvalid(s_valid[3]),
    .s_axis_tready(sr[3]), .m_axis_tdata(md_d), .m_axis_tvalid(mv[3]),
    .m_axis_tready(mr[3]), .m_axis_tlast(ml[3]), .blocks_done(bd[3]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input int d, input logic [7:0] x);
    logic ok;
    int n = 0;
    s_data[d] = x;
    s_valid[d] = 1;
    do begin
      @(negedge clk);
      ok = sr[d];
      @(posedge clk);
      n++;
    end while (!ok && n < 200);
    #1 s_valid[d] = 0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: dut %0d element %h not accepted in 200 cycles", d, x);
    end
  endtask

  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding, expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) begin
      q.push_back('{vecs[v].d, vecs[v].data, vecs[v].last});
      for (int i = 0; i < vecs[v].n; i++) begin
        send(vecs[v].d, vecs[v].first + 8'(i));
        chk("latency_valid", 64'(mv[vecs[v].d]), 64'(i == vecs[v].n - 1));
      end
    end
  endtask

  initial begin
    vecs = '{
      '{0, 8'h01, 4, 32'h04030201, 0}, '{0, 8'h05, 4, 32'h08070605, 0},
      '{0, 8'h09, 4, 32'h0C0B0A09, 0}, '{0, 8'h0D, 4, 32'h100F0E0D, 1},
      '{1, 8'h01, 4, 32'h04030201, 0}, '{1, 8'h05, 4, 32'h08070605, 0},
      '{1, 8'h09, 2, 32'h00000A09, 1}, '{1, 8'h11, 4, 32'h14131211, 0},
      '{1, 8'h15, 4, 32'h18171615, 0}, '{1, 8'h19, 2, 32'h00001A19, 1},
      '{2, 8'hA0, 1, 32'hA0, 0}, '{2, 8'hA1, 1, 32'hA1, 0}, '{2, 8'hA2, 1, 32'hA2, 1},
      '{2, 8'hA3, 1, 32'hA3, 0}, '{2, 8'hA4, 1, 32'hA4, 0}, '{2, 8'hA5, 1, 32'hA5, 1},
      '{0, 8'h11, 4, 32'h14131211, 0}, '{0, 8'h15, 4, 32'h18171615, 0},
      '{0, 8'h19, 4, 32'h1C1B1A19, 0}, '{0, 8'h1D, 4, 32'h201F1E1D, 1}};
    for (int d = 0; d < 4; d++) begin
      s_data[d] = 0;
      s_valid[d] = 0;
      mr[d] = 1;
      stalled[d] = 0;
      hold[d] = 0;
    end
    fork
      forever begin
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
          if (!rst && stalled[d] && mv[d]) chk("hold_stable", 64'({ml[d], md[d]}), 64'(hold[d]));
          if (!rst && mv[d] && mr[d]) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL beat_unexpected: dut %0d produced %h, expected no beat", d, md[d]);
            end else begin
              mon_e = q.pop_front();
              chk("beat_dut", 64'(d), 64'(mon_e.d));
              chk("beat_data", 64'(md[d]), 64'(mon_e.data));
              chk("beat_last", 64'(ml[d]), 64'(mon_e.last));
            end
          end
          stalled[d] = !rst && mv[d] && !mr[d];
          hold[d] = {ml[d], md[d]};
        end
      end
      forever begin
        @(posedge clk);
        #2 if (rand_on) mr[3] = 1'($urandom_range(0, 1));
      end
    join_none
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("reset_valid", 64'(mv[d]), 0);
      chk("reset_data", 64'(md[d]), 0);
      chk("reset_last", 64'(ml[d]), 0);
      chk("reset_blocks", 64'(bd[d]), 0);
    end
    rst = 0;
    @(posedge clk);
    #1;
    run_vecs(0, 3);
    drain();
    chk("blocks_a1", 64'(bd[0]), 1);
    for (int k = 0; k < 4; k++)
      q.push_back('{0, {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)}, k == 3});
    mr[0] = 0;
    fork
      for (int k = 1; k <= 16; k++) send(0, 8'(k));
      begin
        int n = 0;
        while (!mv[0] && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("stall_valid", 64'(mv[0]), 1);
        repeat (10) begin
          @(negedge clk);
          chk("stall_ready", 64'(sr[0]), 0);
          chk("stall_data", 64'(md[0]), 64'h04030201);
        end
        @(posedge clk);
        #2 mr[0] = 1;
      end
    join
    drain();
    chk("blocks_a2", 64'(bd[0]), 2);
    run_vecs(4, 9);
    drain();
    chk("blocks_b", 64'(bd[1]), 2);
    run_vecs(10, 15);
    drain();
    chk("blocks_c", 64'(bd[2]), 2);
    q.push_back('{0, 32'h04030201, 0});
    for (int k = 1; k <= 6; k++) send(0, 8'(k));
    #2 rst = 1;
    #1;
    chk("async_rst_valid", 64'(mv[0]), 0);
    chk("async_rst_data", 64'(md[0]), 0);
    chk("async_rst_blocks", 64'(bd[0]), 0);
    chk("async_rst_queue", 64'(q.size()), 0);
    @(posedge clk);
    #1 rst = 0;
    run_vecs(16, 19);
    drain();
    chk("blocks_after_rst", 64'(bd[0]), 1);
    rand_on = 1;
    for (int b = 0; b < 1000; b++) begin
      logic [31:0] word = 0;
      int cnt = 0;
      for (int e = 0; e < 7; e++) begin
        logic [7:0] x = 8'($urandom);
        word |= 32'(x) << (8 * cnt);
        cnt++;
        if (cnt == 3 || e == 6) begin
          q.push_back('{3, word, e == 6});
          word = 0;
          cnt = 0;
        end
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk);
          #1;
        end
        send(3, x);
      end
    end
    drain();
    chk("blocks_d", 64'(bd[3]), 1000);
    rand_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
